// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

    localparam int unsigned SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

endpackage

// File: rtl/tdm_demux4_slot_cnt4.sv
// 2-bit slot counter: clear-to-0 beats load-to-1 beats increment.
module slot_cnt4
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  load1_i,
    input  logic  inc_i,
    output slot_t slot_o
);

    slot_t slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= slot_t'(0);
        end else if (clr_i) begin
            slot_q <= slot_t'(0);
        end else if (load1_i) begin
            slot_q <= slot_t'(1);
        end else if (inc_i) begin
            slot_q <= slot_q + slot_t'(1);
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// TDM 1-to-4 demultiplexer: aligns on sync, collects slots 0-3 and
// publishes them as a complete frame on the slot-3 edge.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         en,
    input  logic         sync,
    output logic [W-1:0] o0,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3,
    output logic         s1,
    output logic         s0,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    state_t       state_q, state_d;
    logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [W-1:0] o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
    logic         fv_q, fv_d, se_q, se_d;
    logic         cnt_clr, cnt_load1, cnt_inc;
    slot_t        slot;

    slot_cnt4 u_slot_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .slot_o  (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            o0_q    <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            o3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            o0_q    <= o0_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            o3_q    <= o3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    // A sync always restarts the frame at slot 1; any sync off slot 0 in LOCK is a realign.
    always_comb begin
        state_d   = state_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        o0_d      = o0_q;
        o1_d      = o1_q;
        o2_d      = o2_q;
        o3_d      = o3_q;
        fv_d      = 1'b0;
        se_d      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (en) begin
            if (sync) begin
                sh0_d     = din;
                cnt_load1 = 1'b1;
                state_d   = LOCK;
                se_d      = (state_q == LOCK) && (slot != slot_t'(0));
            end else if (state_q == LOCK) begin
                if (slot == slot_t'(0)) begin
                    se_d    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = HUNT;
                end else if (slot == LAST_SLOT) begin
                    o0_d    = sh0_q;
                    o1_d    = sh1_q;
                    o2_d    = sh2_q;
                    o3_d    = din;
                    fv_d    = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    if (slot == slot_t'(1)) begin
                        sh1_d = din;
                    end else begin
                        sh2_d = din;
                    end
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    assign o0          = o0_q;
    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign s1          = slot[1];
    assign s0          = slot[0];
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with W=4 and hand-computed expectations.
module tb_tdm_demux4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         en;
    logic         sync;
    logic [W-1:0] o0, o1, o2, o3;
    logic         s1, s0;
    logic         frame_valid, locked, sync_err;

    int total = 0;
    int bad   = 0;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .o0          (o0),
        .o1          (o1),
        .o2          (o2),
        .o3          (o3),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample at a falling edge; return at the next falling edge.
    task automatic drive(input logic [W-1:0] d, input logic e, input logic s);
        din  = d;
        en   = e;
        sync = s;
        @(negedge clk);
    endtask

    // {locked, sync_err, frame_valid, s1, s0}
    function automatic logic [31:0] flags();
        return 32'({locked, sync_err, frame_valid, s1, s0});
    endfunction

    function automatic logic [31:0] lanes();
        return 32'({o0, o1, o2, o3});
    endfunction

    initial begin
        rst  = 1'b1;
        din  = '0;
        en   = 1'b0;
        sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_lanes", lanes(), 32'h0000);
        chk("reset_flags", flags(), 32'b00000);
        rst = 1'b0;

        // Aligned stream 0,1,1,0
        drive(4'h0, 1'b1, 1'b1);
        chk("f1_s0_flags", flags(), 32'b10001);
        drive(4'h1, 1'b1, 1'b0);
        chk("f1_s1_flags", flags(), 32'b10010);
        drive(4'h1, 1'b1, 1'b0);
        chk("f1_s2_flags", flags(), 32'b10011);
        drive(4'h0, 1'b1, 1'b0);
        chk("f1_done_flags", flags(), 32'b10100);
        chk("f1_lanes", lanes(), 32'h0110);
        drive(4'h0, 1'b0, 1'b0);
        chk("f1_pulse_end", flags(), 32'b10000);

        // Stall of 3 cycles between slots 1 and 2
        drive(4'h1, 1'b1, 1'b1);
        drive(4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 1'b0, 1'b1);
            chk("stall_flags", flags(), 32'b10010);
            chk("stall_lanes", lanes(), 32'h0110);
        end
        drive(4'h0, 1'b1, 1'b0);
        chk("stall_s3_flags", flags(), 32'b10011);
        drive(4'h1, 1'b1, 1'b0);
        chk("stall_done_flags", flags(), 32'b10100);
        chk("stall_lanes_new", lanes(), 32'h1001);
        drive(4'h0, 1'b0, 1'b0);
        chk("stall_pulse_end", flags(), 32'b10000);

        // Early sync on slot 2 realigns
        drive(4'h5, 1'b1, 1'b1);
        drive(4'h6, 1'b1, 1'b0);
        drive(4'h7, 1'b1, 1'b1);
        chk("early_flags", flags(), 32'b11001);
        chk("early_lanes", lanes(), 32'h1001);
        drive(4'h8, 1'b1, 1'b0);
        chk("early_err_end", flags(), 32'b10010);
        drive(4'h9, 1'b1, 1'b0);
        drive(4'hA, 1'b1, 1'b0);
        chk("resync_flags", flags(), 32'b10100);
        chk("resync_lanes", lanes(), 32'h789A);

        // Missing sync at slot 0 drops to HUNT
        drive(4'h3, 1'b1, 1'b0);
        chk("miss_flags", flags(), 32'b01000);
        drive(4'h4, 1'b1, 1'b0);
        chk("hunt_ignore1", flags(), 32'b00000);
        drive(4'h5, 1'b1, 1'b0);
        chk("hunt_ignore2", flags(), 32'b00000);
        chk("hunt_lanes", lanes(), 32'h789A);

        // Asynchronous reset at slot 2
        drive(4'h1, 1'b1, 1'b1);
        drive(4'h2, 1'b1, 1'b0);
        chk("pre_rst_flags", flags(), 32'b10010);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lanes", lanes(), 32'h0000);
        chk("async_rst_flags", flags(), 32'b00000);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h3, 1'b1, 1'b0);
        chk("post_rst_hunt", flags(), 32'b00000);
        drive(4'h4, 1'b1, 1'b0);
        chk("post_rst_lanes", lanes(), 32'h0000);

        // Back-to-back frames
        drive(4'hA, 1'b1, 1'b1);
        chk("b2b_a_start", flags(), 32'b10001);
        drive(4'hB, 1'b1, 1'b0);
        drive(4'hC, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        chk("b2b_a_flags", flags(), 32'b10100);
        chk("b2b_a_lanes", lanes(), 32'hABCD);
        drive(4'h1, 1'b1, 1'b1);
        chk("b2b_b_start", flags(), 32'b10001);
        drive(4'h2, 1'b1, 1'b0);
        drive(4'h3, 1'b1, 1'b0);
        chk("b2b_b_hold", lanes(), 32'hABCD);
        drive(4'h4, 1'b1, 1'b0);
        chk("b2b_b_flags", flags(), 32'b10100);
        chk("b2b_b_lanes", lanes(), 32'h1234);
        drive(4'hF, 1'b1, 1'b1);
        drive(4'hE, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        drive(4'hC, 1'b1, 1'b0);
        chk("b2b_c_flags", flags(), 32'b10100);
        chk("b2b_c_lanes", lanes(), 32'hFEDC);
        drive(4'h0, 1'b0, 1'b0);
        chk("b2b_end", flags(), 32'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division 1-to-4 demultiplexer: the receive end of the 4-slot TDM link driven by the 4:1 mux path. It accepts one sample per enabled cycle, identifies slot 0 from a sync marker, and distributes slots 0–3 into four registered output lanes. It asserts a one-cycle frame strobe when a complete frame has been captured. A HUNT/LOCK state machine tracks alignment and flags sync violations.

## Interface
Parameters:
- W, 1, sample/lane width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  W  serial TDM sample
- en  in  1  din/sync valid this cycle; en=0 stalls the block
- sync  in  1  marks din as slot 0; qualified by en
- o0, o1, o2, o3  out  W  registered lane outputs, slots 0–3 of the last complete frame
- s1, s0  out  1 each  slot index the next enabled sample will be written to (s1 is the MSB)
- frame_valid  out  1  one-cycle pulse; o0–o3 were updated by the previous edge
- locked  out  1  high while in LOCK
- sync_err  out  1  one-cycle pulse on an alignment violation

## Operation
- Reset (async, immediate): state=HUNT, slot=0, shadow regs=0, o0–o3=0, frame_valid=0, locked=0, sync_err=0, {s1,s0}=00.
- Internals: 2-bit slot counter; shadow registers sh0–sh2 (W bits each); state HUNT or LOCK.
- HUNT:
  - en&&sync: sh0<=din, slot<=1, go to LOCK.
  - All other cycles: no change. Samples without sync are discarded silently; sync_err stays 0.
- LOCK, en=1:
  - slot 0, sync=1: sh0<=din, slot<=1.
  - slot 0, sync=0: sync_err pulse, sample discarded, go to HUNT, slot<=0.
  - slot 1–2, sync=0: sh[slot]<=din, slot++.
  - slot 3, sync=0: o0<=sh0, o1<=sh1, o2<=sh2, o3<=din, slot<=0, frame_valid pulse.
  - slot 1–3, sync=1: realign. sync_err pulse, partial frame dropped (o0–o3 untouched, no frame_valid), sh0<=din, slot<=1, stay in LOCK.
- en=0 in any state: all registers hold. frame_valid and sync_err are 0.
- o0–o3 change only on a completed frame and hold between frames.
- locked mirrors the state register.
- Sample data is never modified; no arithmetic is performed on it. The slot counter wraps 3->0 modulo 4.

## Timing
- Latency: o0–o3 update on the same edge that captures the slot-3 sample. frame_valid is high for exactly the following cycle.
- Minimum frame period is 4 enabled cycles, giving at most one frame_valid per 4 clocks. Back-to-back frames produce frame_valid every 4th cycle with no bubble.
- sync_err is high for exactly one cycle, the cycle after the offending edge.
- s1/s0 are registered and equal the slot counter. They read 00 in HUNT.
- locked rises in the cycle after the first accepted sync and falls in the cycle after a slot-0 sample without sync.
- Reset asserted mid-frame: the partial frame is lost, outputs clear immediately, and no pulse is emitted. After reset deassertion the block waits in HUNT for sync.
- frame_valid and sync_err are never high in the same cycle.

## Structure
- Shared package tdm_pkg contains:
  - state enum {HUNT, LOCK}
  - SLOTS=4 constant
  - slot index type (2 bits)
- One sub-module, slot_cnt4: 2-bit counter with enable, load-to-1, clear-to-0, and async rst. It drives s1/s0 directly.
- The top level holds the FSM, the shadow registers and the output registers.

## Test plan
- Reset then aligned stream, W=1: din 0,1,1,0 with sync on the first sample, en=1 -> o0..o3=0,1,1,0; frame_valid pulses once, 1 cycle after the 4th sample; locked=1.
- Stalls: same frame with en=0 for 3 cycles between slots 1 and 2 -> o0..o3 and s1/s0 hold during the stall; frame_valid is delayed by 3 cycles and is still a single pulse.
- Early sync: sync on slot 2 of frame 2 -> sync_err pulse; o0..o3 keep frame 1 values; the next 4 samples, starting with the resync sample, produce a frame.
- Missing sync at slot 0 -> sync_err pulse, locked=0, {s1,s0}=00; subsequent samples without sync are ignored until the next sync.
- Reset asserted at slot 2 -> o0..o3=0, locked=0 and frame_valid=0 immediately, without waiting for a clock edge; no frame emitted.
- Back-to-back frames, 3 frames with W=4: frames A,B,C,D / 1,2,3,4 / F,E,D,C -> frame_valid at cycles 5, 9 and 13, with lanes matching each frame.
